host_cmd_issuer: RTL

- Host-side command queue and issuer that sits directly upstream of the matrix unit control FSM and drives its 8-bit `host_instruction` input.
- Buffers host commands in a small FIFO.
- Presents each legal command to the FSM for exactly one cycle, then drives a no-op that keeps the DD/AA fields.
- Uses the FSM's registered `busy` flag to know when the next command can be issued.

---
 rtl/host_cmd_issuer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/host_cmd_issuer.sv
// Host command FIFO and single-shot issuer feeding the matrix unit control FSM.
// Each legal command is driven for one cycle, then a DD/AA-preserving no-op until the FSM returns idle.
module host_cmd_issuer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cmd_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              flush,
    input  logic              busy,
    output logic [7:0]        host_instruction,
    output logic              issue_pulse,
    output logic              done_pulse,
    output logic              drop_pulse,
    output logic [ADDR_W:0]   q_count,
    output logic              q_empty,
    output logic              q_full,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic [7:0]         instr_q, instr_d;
    logic               issue_q, issue_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               push, pop;
    logic [7:0]         head;

    assign cmd_ready = !full_q && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Issuer: pop/issue/discard decisions and handshake tracking with the FSM busy flag
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        issue_d = 1'b0;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q && !busy && !flush) begin
                    pop = 1'b1;
                    // op[2] set covers exactly the legal groups 01xx and 11xx
                    if (head[2]) begin
                        instr_d = head;
                        issue_d = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                instr_d = {instr_q[7:4], 4'h0};
                tmo_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_W'(ACK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers and occupancy; flush wins over any push and blocks the pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            instr_q  <= 8'h00;
            issue_q  <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            instr_q  <= instr_d;
            issue_q  <= issue_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign host_instruction = instr_q;
    assign issue_pulse      = issue_q;
    assign done_pulse       = done_q;
    assign drop_pulse       = drop_q;
    assign q_count          = count_q;
    assign q_empty          = empty_q;
    assign q_full           = full_q;
    assign timeout_err      = err_q;

endmodule
